// File: rtl/quad_pkg.sv
// Purpose: shared phase-state encoding, up-successor helper and error-count limit for the quadrature decoder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Ports: none.
package quad_pkg;

  // Phase state encoded as {a, b}; the up sequence is 00 -> 10 -> 11 -> 01 -> 00.
  typedef enum logic [1:0] {
    QS_00 = 2'b00,
    QS_10 = 2'b10,
    QS_11 = 2'b11,
    QS_01 = 2'b01
  } qstate_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  // Next state when the encoder moves one position in the up direction.
  function automatic qstate_t up_next(input qstate_t s);
    qstate_t n;
    case (s)
      QS_00:   n = QS_10;
      QS_10:   n = QS_11;
      QS_11:   n = QS_01;
      default: n = QS_00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Purpose: metastability synchronizer for one encoder phase, optionally followed by a glitch filter (QUAD_GLITCH_FILTER_EN).
// Latency: SYNC_STAGES-1 edges from first sampling edge to dout, plus FILT_LEN edges when the filter is built in.
// Backpressure: none; free-running, a new sample every cycle.
// Ports: clk, rst (sync, active-low), din (async phase in), dout (clean phase out).
module quad_sync_filter #(
  parameter int SYNC_STAGES = 2
`ifdef QUAD_GLITCH_FILTER_EN
  ,
  parameter int FILT_LEN = 3
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  // Bit 0 captures the asynchronous input; the MSB is the synchronized value.
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

`ifdef QUAD_GLITCH_FILTER_EN
  localparam int CNT_W = $clog2(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The phase is binary, so a run of consecutive samples that differ from the
  // accepted value is a run of the same new value. Accept it on the FILT_LEN-th
  // such sample; any sample matching the accepted value restarts the run.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_out != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_out;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = filt_q;
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout = sync_out;
`endif

endmodule

// File: rtl/quad_step_decoder.sv
// Purpose: quadrature A/B decoder producing step/dir pulses, illegal-jump err pulses and a saturating err_cnt.
// Latency: SYNC_STAGES+1 edges from input change to step/err (plus FILT_LEN with QUAD_GLITCH_FILTER_EN).
// Backpressure: none; events are single-cycle pulses, en=0 drops them (and blocks err_cnt) rather than stalling.
// Ports: clk, rst (sync, active-low), qa/qb (async phases), en, clr_err -> step, dir, err, err_cnt[7:0].
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       qa,
  input  logic       qb,
  input  logic       en,
  input  logic       clr_err,
  output logic       step,
  output logic       dir,
  output logic       err,
  output logic [7:0] err_cnt
);

`ifdef QUAD_GLITCH_FILTER_EN
  localparam int FILT_EN = 1;
`else
  localparam int FILT_EN = 0;
`endif

  // Warm-up covers the time for post-reset zeros to flush through the input path.
  localparam int WARM_CYCLES = SYNC_STAGES + FILT_EN * FILT_LEN;
  localparam int WARM_W      = $clog2(WARM_CYCLES);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM_CYCLES - 1);

  logic    a_clean, b_clean;
  qstate_t cur;

`ifdef QUAD_GLITCH_FILTER_EN
  quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sync_a (
    .clk(clk), .rst(rst), .din(qa), .dout(a_clean)
  );
  quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sync_b (
    .clk(clk), .rst(rst), .din(qb), .dout(b_clean)
  );
`else
  quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk(clk), .rst(rst), .din(qa), .dout(a_clean)
  );
  quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk(clk), .rst(rst), .din(qb), .dout(b_clean)
  );
`endif

  assign cur = qstate_t'({a_clean, b_clean});

  qstate_t           prev_q, prev_d;
  logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
  logic              primed_q, primed_d;
  logic              step_q, step_d;
  logic              dir_q, dir_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic is_fwd, is_rev, active;

  always_comb begin
    // prev follows cur unconditionally so a disabled or warming-up period never
    // leaves a stale state behind to be reported later.
    prev_d     = cur;
    warm_cnt_d = warm_cnt_q;
    primed_d   = primed_q;
    if (!primed_q) begin
      if (warm_cnt_q == WARM_LAST) begin
        primed_d = 1'b1;
      end else begin
        warm_cnt_d = warm_cnt_q + 1'b1;
      end
    end

    // A single-bit change is always one of the two neighbours; anything else
    // that differs must have flipped both bits.
    is_fwd = (cur == up_next(prev_q));
    is_rev = (prev_q == up_next(cur));
    active = primed_q && en && (cur != prev_q);

    step_d = active && (is_fwd || is_rev);
    err_d  = active && !(is_fwd || is_rev);
    dir_d  = step_d ? is_fwd : dir_q;

    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = 8'd0;
    end else if (err_d && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q     <= QS_00;
      warm_cnt_q <= '0;
      primed_q   <= 1'b0;
      step_q     <= 1'b0;
      dir_q      <= 1'b1;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      prev_q     <= prev_d;
      warm_cnt_q <= warm_cnt_d;
      primed_q   <= primed_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign step    = step_q;
  assign dir     = dir_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Purpose: self-checking bench for quad_step_decoder (directed scenarios plus random stimulus vs a behavioural model).
// Latency: n/a.
// Backpressure: n/a.
module tb_quad_step_decoder;

  localparam int S = 2;
  localparam int F = 3;
`ifdef QUAD_GLITCH_FILTER_EN
  localparam int FE = 1;
`else
  localparam int FE = 0;
`endif
  localparam int WARM = S + FE * F;
  localparam int LAT  = S + 1 + FE * F;
  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst, qa, qb, en, clr_err;
  logic       step, dir, err;
  logic [7:0] err_cnt;

  quad_step_decoder #(.SYNC_STAGES(S), .FILT_LEN(F)) dut (
    .clk(clk), .rst(rst), .qa(qa), .qb(qb), .en(en), .clr_err(clr_err),
    .step(step), .dir(dir), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Position on the encoder wheel; (cur - prev) mod 4 gives 1 = up, 3 = down, 2 = jump.
  function automatic int pos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  logic [1:0] m_syn   [S];   // raw samples, [0] newest
  logic [1:0] m_shist [F];   // synchronized values seen by the filter, [0] newest
  logic [1:0] m_filt, m_cur, m_prev;
  logic       m_step, m_dir, m_err;
  int         m_cnt;
  int         m_edges;
  int         edge_cnt = 0;

  always @(posedge clk) begin
    int  d;
    logic same;
    edge_cnt++;
    if (!rst) begin
      foreach (m_syn[i]) m_syn[i] = 2'b00;
      foreach (m_shist[i]) m_shist[i] = 2'b00;
      m_filt = 2'b00; m_cur = 2'b00; m_prev = 2'b00;
      m_step = 1'b0; m_dir = 1'b1; m_err = 1'b0; m_cnt = 0; m_edges = 0;
    end else begin
      m_edges++;
      m_step = 1'b0;
      m_err  = 1'b0;
      if (m_edges > WARM && en && m_cur != m_prev) begin
        d = (pos(m_cur) - pos(m_prev) + 4) % 4;
        if (d == 1) begin m_step = 1'b1; m_dir = 1'b1; end
        else if (d == 3) begin m_step = 1'b1; m_dir = 1'b0; end
        else m_err = 1'b1;
      end
      if (clr_err) m_cnt = 0;
      else if (m_err && m_cnt < 255) m_cnt++;
      m_prev = m_cur;
      if (FE != 0) begin
        for (int i = F - 1; i > 0; i--) m_shist[i] = m_shist[i-1];
        m_shist[0] = m_syn[S-1];
        for (int b = 0; b < 2; b++) begin
          same = 1'b1;
          for (int i = 1; i < F; i++) if (m_shist[i][b] != m_shist[0][b]) same = 1'b0;
          if (same) m_filt[b] = m_shist[0][b];
        end
        m_cur = m_filt;
      end
      for (int i = S - 1; i > 0; i--) m_syn[i] = m_syn[i-1];
      m_syn[0] = {qa, qb};
      if (FE == 0) m_cur = m_syn[S-1];
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_step = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got=%0d expected=%0d", name, edge_cnt, got, exp);
    end
  endtask

  // One cycle: wait for the falling edge, compare against the model, tally pulses.
  task automatic tick();
    @(negedge clk);
    if (chk_on) begin
      chk("step", 32'(step), 32'(m_step));
      chk("dir", 32'(dir), 32'(m_dir));
      chk("err", 32'(err), 32'(m_err));
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
    end
    if (step === 1'b1) n_step++;
    if (err === 1'b1) n_err++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go(input logic [1:0] s, input int n);
    {qa, qb} = s;
    ticks(n);
  endtask

  logic [1:0] up_seq [4];
  logic [1:0] mix_seq [5];
  int base_s, base_e, lat, c0;

  initial begin
    up_seq  = '{2'b10, 2'b11, 2'b01, 2'b00};
    mix_seq = '{2'b10, 2'b11, 2'b10, 2'b00, 2'b01};
    rst = 1'b0; qa = 1'b0; qb = 1'b0; en = 1'b1; clr_err = 1'b0;
    ticks(2);
    chk_on = 1'b1;
    tick();
    chk("reset_dir", 32'(dir), 32'd1);
    rst = 1'b1;

    // Idle after reset.
    base_s = n_step; base_e = n_err;
    ticks(20);
    chk("idle_steps", 32'(n_step - base_s), 32'd0);
    chk("idle_errs", 32'(n_err - base_e), 32'd0);
    chk("idle_err_cnt", 32'(err_cnt), 32'd0);

    // Two full up cycles; measure latency of the first pulse.
    base_s = n_step; lat = -1; c0 = edge_cnt;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) begin
        {qa, qb} = up_seq[k];
        for (int t = 0; t < HOLD; t++) begin
          tick();
          if (step === 1'b1 && lat < 0) lat = edge_cnt - c0;
        end
      end
    chk("up_steps", 32'(n_step - base_s), 32'd8);
    chk("up_dir", 32'(dir), 32'd1);
    chk("first_latency", 32'(lat), 32'(LAT));

    // Up 2 then down 3.
    base_s = n_step;
    for (int k = 0; k < 5; k++) go(mix_seq[k], HOLD);
    chk("mix_steps", 32'(n_step - base_s), 32'd5);
    chk("mix_dir", 32'(dir), 32'd0);

    // Illegal jumps and saturation (state is 01 here).
    go(2'b00, HOLD);
    base_s = n_step; base_e = n_err;
    go(2'b11, HOLD);
    chk("jump_errs", 32'(n_err - base_e), 32'd1);
    chk("jump_steps", 32'(n_step - base_s), 32'd0);
    chk("jump_err_cnt", 32'(err_cnt), 32'd1);
    for (int r = 0; r < 300; r++) go((r % 2 == 0) ? 2'b00 : 2'b11, F + 2);
    ticks(HOLD);
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);
    // clr_err lands on the same edge as the next err pulse.
    {qa, qb} = 2'b00;
    ticks(LAT - 1);
    clr_err = 1'b1;
    tick();
    chk("clr_err_pulse", 32'(err), 32'd1);
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    clr_err = 1'b0;
    ticks(HOLD);

    // Disabled transitions are dropped; re-enable gives exactly one step.
    base_s = n_step;
    en = 1'b0;
    for (int k = 0; k < 4; k++) go(up_seq[k], HOLD);
    en = 1'b1;
    go(2'b10, HOLD);
    chk("en_steps", 32'(n_step - base_s), 32'd1);
    chk("en_err_cnt", 32'(err_cnt), 32'd0);

`ifdef QUAD_GLITCH_FILTER_EN
    go(2'b00, HOLD);
    base_s = n_step; base_e = n_err;
    go(2'b10, F - 1);
    go(2'b00, HOLD);
    chk("glitch_events", 32'(n_step - base_s + n_err - base_e), 32'd0);
    go(2'b10, HOLD);
    chk("filt_steps", 32'(n_step - base_s), 32'd1);
`endif

    // Reset mid-sequence with dir=0 and a non-zero err_cnt.
    go(2'b01, HOLD);
    go(2'b11, HOLD);
    {qa, qb} = 2'b10;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_dir", 32'(dir), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b1;
    ticks(20);

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 18) {qa, qb} = {qa, qb} ^ (2'b01 << $urandom_range(0, 1));
      else if (r < 21) {qa, qb} = {qa, qb} ^ 2'b11;
      if ($urandom_range(0, 49) == 0) en = ~en;
      clr_err = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst = 1'b1; en = 1'b1; clr_err = 1'b0;
    ticks(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
# quad_step_decoder

Quadrature encoder front end that turns two asynchronous phase inputs (A/B) into single-cycle `step` pulses with a `dir` level. The outputs drive the count-enable and `u_d` inputs of the team's 8-bit up/down counter, which holds position. The block also flags illegal phase jumps and keeps a saturating error count.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per phase input; legal range ≥ 2.
- `FILT_LEN`, default 3: consecutive equal samples required by the glitch filter; legal range ≥ 2; used only when the filter is compiled in.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-low reset.
- `qa` input 1: encoder phase A, asynchronous to `clk`.
- `qb` input 1: encoder phase B, asynchronous to `clk`.
- `en` input 1: event enable; when low, `step` and `err` are suppressed.
- `clr_err` input 1: synchronous clear of `err_cnt`.
- `step` output 1: one-cycle pulse per valid quadrature transition.
- `dir` output 1: 1 = up (A leads B), 0 = down; holds last valid direction.
- `err` output 1: one-cycle pulse on an illegal transition (both phases changed).
- `err_cnt` output 8: saturating count of `err` pulses.

## Operation
- Each phase passes through a `SYNC_STAGES`-deep synchronizer, then the optional filter (see Configuration), giving phase state `cur = {a,b}`.
- Register `prev` holds the last accepted state.
- Up sequence: 00→10→11→01→00. Down sequence is the reverse.
- Each cycle, once primed, compare `cur` with `prev`:
  - Equal: no event.
  - Forward neighbour: `step` = 1, `dir` = 1.
  - Reverse neighbour: `step` = 1, `dir` = 0.
  - Both bits differ: `err` = 1, `step` = 0, `dir` unchanged.
- `prev` <= `cur` every cycle, including on error and while `en` = 0. Re-enabling therefore never emits a stale step.
- Priming:
  - After reset, a warm-up counter runs `SYNC_STAGES` (+`FILT_LEN` with the filter) cycles.
  - During warm-up, `prev` tracks `cur` and no events are emitted.
  - The primed flag then sets and stays set until the next reset.
- `err_cnt` increments on each `err` pulse and saturates at 255; it does not wrap.
- `clr_err` = 1 sets `err_cnt` to 0 next cycle. `clr_err` wins over a simultaneous `err`: result is 0, but `err` still pulses.
- `en` = 0 also blocks `err_cnt` increment.
- Reset (`rst` = 0 at a rising edge) mid-operation aborts everything:
  - `step` = 0, `dir` = 1, `err` = 0, `err_cnt` = 0.
  - Synchronizer and filter flops = 0, `prev` = 00, primed = 0.

## Timing
- A level change on `qa`/`qb` first sampled at edge N reaches `cur` after edge N+`SYNC_STAGES`-1.
- `step`/`dir`/`err` are registered and update at edge N+`SYNC_STAGES`.
- Latency is `SYNC_STAGES`+1 edges without the filter, plus `FILT_LEN` with it.
- `step` and `err` are high for exactly one cycle per event and are never high together.
- Max trackable transition rate: one state change per (`FILT_LEN` if filtered, else 1) cycles. Faster changes yield `err` or missed steps; this is legal, not a hang.
- `dir` changes only in the same cycle as a `step` pulse.

## Configuration
- Macro `QUAD_GLITCH_FILTER_EN`.
- Defined: each synchronized phase is accepted only after it is stable for `FILT_LEN` consecutive cycles; shorter pulses are discarded with no event. Adds `FILT_LEN` cycles latency and extends warm-up.
- Undefined: `cur` is the synchronizer output directly; `FILT_LEN` is ignored.

## Structure
- Package `quad_pkg`:
  - State constants `QS_00`, `QS_10`, `QS_11`, `QS_01`.
  - Up-successor function (state → next up state).
  - `ERR_CNT_MAX` = 8'd255.
- Sub-module `quad_sync_filter`: one instance per phase, containing the synchronizer plus the macro-gated filter.
- Top level holds warm-up, transition decode, `dir` and `err_cnt`.

## Test plan
- Reset then idle (qa=qb=0, en=1, 20 cycles) -> no `step`/`err`; `dir`=1, `err_cnt`=0 throughout.
- Drive up sequence 00→10→11→01→00 ×2, each held 8 cycles -> 8 `step` pulses, `dir`=1, first pulse exactly `SYNC_STAGES`+1 edges (no filter) after the qa rise.
- Up 2 steps, then down 3 steps -> 5 pulses; `dir` goes to 0 with the 3rd pulse.
- Jump 00→11 directly -> one `err` pulse, no `step`, `err_cnt`=1; repeat 300 times -> `err_cnt`=255; `clr_err` together with another error -> `err_cnt`=0.
- en=0 for 4 up transitions, then en=1 and 1 more -> exactly 1 `step`; `err_cnt` unchanged.
- With `QUAD_GLITCH_FILTER_EN` defined: qa high for `FILT_LEN`-1 cycles -> no event; held `FILT_LEN` cycles -> one `step`. Assert `rst`=0 mid-sequence -> all outputs at reset values next cycle.
